// File: rtl/cdb_request_queue_pkg.sv
// Shared constants and small helpers for the CDB request queue.
package cdb_request_queue_pkg;

   localparam int unsigned NUM_FU    = 4;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned TAG_W_DEF  = 6;
   localparam int unsigned DEPTH_DEF  = 2;

   // One-hot of the highest set bit, zero if none set.
   function automatic logic [NUM_FU-1:0] highest_onehot(input logic [NUM_FU-1:0] v);
      logic [NUM_FU-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (v[i]) r = NUM_FU'(1) << i;
      end
      return r;
   endfunction

   // True when more than one bit is set.
   function automatic logic multi_hot(input logic [NUM_FU-1:0] v);
      return (v & (v - NUM_FU'(1))) != '0;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-unit result FIFO: DEPTH entries, wrapping pointers, flush clears state.
module cdb_fifo
   import cdb_request_queue_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push_valid,
   input  logic [TAG_W-1:0]  push_tag,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              ready,
   output logic              not_empty,
   output logic [TAG_W-1:0]  head_tag,
   output logic [DATA_W-1:0] head_data
);

   localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned ENTRY_W = TAG_W + DATA_W;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Status comes from the registered count only; a same-cycle pop does not free a slot.
   assign ready     = (count < CNT_W'(DEPTH));
   assign not_empty = (count != '0);
   assign do_push   = push_valid && ready && !flush;
   assign do_pop    = pop && not_empty && !flush;
   assign {head_tag, head_data} = mem[head];

   // Pointer and occupancy tracking; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= wrap_inc(tail);
         if (do_pop)  head <= wrap_inc(head);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= {push_tag, push_data};
   end

endmodule

// File: rtl/cdb_request_queue.sv
// Four per-unit result queues feeding an external fixed-priority CDB arbiter.
module cdb_request_queue
   import cdb_request_queue_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic                     clk_IN,
   input  logic                     reset_n_IN,
   input  logic                     flush_IN,
   input  logic [NUM_FU-1:0]        fu_valid_IN,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag_IN,
   input  logic [NUM_FU*DATA_W-1:0] fu_data_IN,
   output logic [NUM_FU-1:0]        fu_ready_OUT,
   output logic [NUM_FU-1:0]        requests_OUT,
   input  logic [NUM_FU-1:0]        grants_IN,
   output logic                     cdb_valid_OUT,
   output logic [TAG_W-1:0]         cdb_tag_OUT,
   output logic [DATA_W-1:0]        cdb_data_OUT,
   output logic                     grant_err_OUT
);

   logic [TAG_W-1:0]  head_tag  [NUM_FU];
   logic [DATA_W-1:0] head_data [NUM_FU];
   logic [NUM_FU-1:0] pop_sel;
   logic              grant_bad;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_data;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      cdb_fifo #(
         .DATA_W (DATA_W),
         .TAG_W  (TAG_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk        (clk_IN),
         .rst_n      (reset_n_IN),
         .flush      (flush_IN),
         .push_valid (fu_valid_IN[i]),
         .push_tag   (fu_tag_IN[i*TAG_W +: TAG_W]),
         .push_data  (fu_data_IN[i*DATA_W +: DATA_W]),
         .pop        (pop_sel[i]),
         .ready      (fu_ready_OUT[i]),
         .not_empty  (requests_OUT[i]),
         .head_tag   (head_tag[i]),
         .head_data  (head_data[i])
      );
   end

   // Highest-index granted non-empty queue wins; multi-hot or empty-queue grants are errors.
   assign pop_sel   = highest_onehot(grants_IN & requests_OUT);
   assign grant_bad = multi_hot(grants_IN) || ((grants_IN & ~requests_OUT) != '0);

   // Head-entry mux for the popped queue.
   always_comb begin
      sel_tag  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (pop_sel[i]) begin
            sel_tag  = head_tag[i];
            sel_data = head_data[i];
         end
      end
   end

   // Registered CDB broadcast and sticky grant error.
   always_ff @(posedge clk_IN or negedge reset_n_IN) begin
      if (!reset_n_IN) begin
         cdb_valid_OUT <= 1'b0;
         cdb_tag_OUT   <= '0;
         cdb_data_OUT  <= '0;
         grant_err_OUT <= 1'b0;
      end else begin
         cdb_valid_OUT <= (pop_sel != '0) && !flush_IN;
         if ((pop_sel != '0) && !flush_IN) begin
            cdb_tag_OUT  <= sel_tag;
            cdb_data_OUT <= sel_data;
         end
         if (grant_bad) grant_err_OUT <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cdb_request_queue.sv
// Scoreboard bench for cdb_request_queue against a queue-based reference model.
module tb_cdb_request_queue;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 6;
   localparam int DEPTH  = 2;

   logic                  clk;
   logic                  rst_n;
   logic                  flush;
   logic [3:0]            fu_valid;
   logic [4*TAG_W-1:0]    fu_tag;
   logic [4*DATA_W-1:0]   fu_data;
   logic [3:0]            fu_ready;
   logic [3:0]            requests;
   logic [3:0]            grants;
   logic                  cdb_valid;
   logic [TAG_W-1:0]      cdb_tag;
   logic [DATA_W-1:0]     cdb_data;
   logic                  grant_err;

   cdb_request_queue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk_IN        (clk),
      .reset_n_IN    (rst_n),
      .flush_IN      (flush),
      .fu_valid_IN   (fu_valid),
      .fu_tag_IN     (fu_tag),
      .fu_data_IN    (fu_data),
      .fu_ready_OUT  (fu_ready),
      .requests_OUT  (requests),
      .grants_IN     (grants),
      .cdb_valid_OUT (cdb_valid),
      .cdb_tag_OUT   (cdb_tag),
      .cdb_data_OUT  (cdb_data),
      .grant_err_OUT (grant_err)
   );

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } ent_t;

   typedef struct packed {
      logic              valid;
      logic              err;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } exp_t;

   ent_t  mq [4][$];
   exp_t  sb [$];
   ent_t  pe [4];
   logic  err_m;
   int    checks;
   int    failures;
   bit    started;
   exp_t  mon_x;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_req();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
      return r;
   endfunction

   function automatic logic [3:0] model_rdy();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mq[i].size() < DEPTH);
      return r;
   endfunction

   // Arbiter stand-in: highest-index requesting unit wins.
   function automatic logic [3:0] fp_grant();
      logic [3:0] r;
      r = model_req();
      for (int i = 3; i >= 0; i--) begin
         if (r[i]) return 4'(1 << i);
      end
      return 4'b0000;
   endfunction

   task automatic set_push(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
      pe[i].tag  = t;
      pe[i].data = d;
   endtask

   // One cycle: drive inputs at negedge, check status, advance the model, queue the expected broadcast.
   task automatic step(input logic fl, input logic [3:0] v, input logic [3:0] g);
      logic [3:0] req;
      logic [3:0] rdy;
      int         sel;
      int         ones;
      exp_t       x;
      ent_t       e;
      @(negedge clk);
      flush    = fl;
      fu_valid = v;
      grants   = g;
      for (int i = 0; i < 4; i++) begin
         fu_tag[i*TAG_W +: TAG_W]    = pe[i].tag;
         fu_data[i*DATA_W +: DATA_W] = pe[i].data;
      end
      req = model_req();
      rdy = model_rdy();
      check("requests", 64'(requests), 64'(req));
      check("fu_ready", 64'(fu_ready), 64'(rdy));
      ones = $countones(g);
      if (ones > 1 || (g & ~req) != 4'b0000) err_m = 1'b1;
      x = '0;
      x.err = err_m;
      if (fl) begin
         for (int i = 0; i < 4; i++) mq[i].delete();
      end else begin
         sel = -1;
         for (int i = 0; i < 4; i++) begin
            if (g[i] && req[i]) sel = i;
         end
         if (sel >= 0) begin
            e = mq[sel].pop_front();
            x.valid = 1'b1;
            x.tag   = e.tag;
            x.data  = e.data;
         end
         for (int i = 0; i < 4; i++) begin
            if (v[i] && rdy[i]) mq[i].push_back(pe[i]);
         end
      end
      sb.push_back(x);
      started = 1'b1;
   endtask

   task automatic idle();
      step(1'b0, 4'b0000, 4'b0000);
   endtask

   task automatic grant_step();
      step(1'b0, 4'b0000, fp_grant());
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear without a clock.
   task automatic async_reset();
      exp_t x;
      @(negedge clk);
      flush    = 1'b0;
      fu_valid = 4'b0000;
      grants   = 4'b0000;
      for (int i = 0; i < 4; i++) mq[i].delete();
      err_m = 1'b0;
      x = '0;
      sb.push_back(x);
      #2 rst_n = 1'b0;
      #1;
      check("rst_requests", 64'(requests), 64'h0);
      check("rst_fu_ready", 64'(fu_ready), 64'hf);
      check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
      check("rst_cdb_tag", 64'(cdb_tag), 64'h0);
      check("rst_cdb_data", 64'(cdb_data), 64'h0);
      check("rst_grant_err", 64'(grant_err), 64'h0);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: one expected record per clock edge, compared just after the edge.
   always @(posedge clk) begin
      #1;
      if (started) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got empty expected entry at %0t", $time);
         end else begin
            mon_x = sb.pop_front();
            check("cdb_valid", 64'(cdb_valid), 64'(mon_x.valid));
            if (mon_x.valid) begin
               check("cdb_tag", 64'(cdb_tag), 64'(mon_x.tag));
               check("cdb_data", 64'(cdb_data), 64'(mon_x.data));
            end
            check("grant_err", 64'(grant_err), 64'(mon_x.err));
         end
      end
   end

   initial begin
      logic [3:0] g;
      logic       fl;
      int         r;
      checks   = 0;
      failures = 0;
      started  = 1'b0;
      err_m    = 1'b0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      fu_valid = 4'b0000;
      grants   = 4'b0000;
      fu_tag   = '0;
      fu_data  = '0;
      for (int i = 0; i < 4; i++) set_push(i, '0, '0);
      #12;
      check("reset_requests", 64'(requests), 64'h0);
      check("reset_fu_ready", 64'(fu_ready), 64'hf);
      check("reset_cdb_valid", 64'(cdb_valid), 64'h0);
      check("reset_cdb_tag", 64'(cdb_tag), 64'h0);
      check("reset_cdb_data", 64'(cdb_data), 64'h0);
      check("reset_grant_err", 64'(grant_err), 64'h0);
      #5 rst_n = 1'b1;

      // Single push on unit 0, grant echoing request.
      set_push(0, 6'h05, 32'hDEADBEEF);
      step(1'b0, 4'b0001, 4'b0000);
      grant_step();
      idle();

      // Units 3 and 1 together: unit 3 broadcasts first.
      set_push(3, 6'h33, 32'h3333_0003);
      set_push(1, 6'h11, 32'h1111_0001);
      step(1'b0, 4'b1010, 4'b0000);
      grant_step();
      grant_step();
      idle();

      // Three pushes into unit 2 with no grants; the third is dropped.
      for (int k = 0; k < 3; k++) begin
         set_push(2, 6'(k + 8), 32'hA000_0000 + 32'(k));
         step(1'b0, 4'b0100, 4'b0000);
      end
      grant_step();
      grant_step();
      grant_step();
      idle();

      // Unit 1 with one entry: simultaneous push and pop.
      set_push(1, 6'h21, 32'h0000_0021);
      step(1'b0, 4'b0010, 4'b0000);
      set_push(1, 6'h22, 32'h0000_0022);
      step(1'b0, 4'b0010, 4'b0010);
      grant_step();
      grant_step();
      idle();

      // Multi-hot grant, then grant to an empty queue.
      set_push(1, 6'h31, 32'h0000_0131);
      set_push(2, 6'h32, 32'h0000_0232);
      step(1'b0, 4'b0110, 4'b0000);
      step(1'b0, 4'b0000, 4'b0110);
      step(1'b0, 4'b0000, 4'b1000);
      grant_step();
      idle();

      // Fill all queues, then flush alongside a grant.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) set_push(i, 6'(16 + 4*k + i), 32'hF000_0000 + 32'(4*k + i));
         step(1'b0, 4'b1111, 4'b0000);
      end
      step(1'b1, 4'b0000, fp_grant());
      idle();

      // Async reset mid-fill.
      for (int i = 0; i < 4; i++) set_push(i, 6'(40 + i), 32'hE000_0000 + 32'(i));
      step(1'b0, 4'b1111, 4'b0000);
      step(1'b0, 4'b0101, fp_grant());
      async_reset();
      idle();

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++) set_push(i, TAG_W'($urandom), $urandom);
         r = $urandom_range(0, 99);
         if (r < 70)      g = fp_grant();
         else if (r < 85) g = 4'($urandom);
         else             g = 4'b0000;
         fl = ($urandom_range(0, 99) < 4);
         if (fl) g = fp_grant();
         if (n == 200) async_reset();
         step(fl, 4'($urandom), g);
      end
      idle();

      @(posedge clk);
      #2;
      started = 1'b0;
      check("sb_drained", 64'(sb.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
